// File: rtl/sram_ctrl_pkg.sv
// Shared constants and FSM state type for the 64x64 SRAM controller.
package sram_ctrl_pkg;

    localparam int DW    = 64;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sram_ctrl_64x64_if.sv
// Request/response handshake bundle between a client and the SRAM controller.
interface sram_ctrl_64x64_if #(
    parameter int DW = sram_ctrl_pkg::DW,
    parameter int AW = sram_ctrl_pkg::AW
);
    import sram_ctrl_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, init_done
    );

endinterface

// File: rtl/sram_resp_fifo.sv
// Two-entry registered response queue; a push into a full queue is taken when a pop
// happens in the same cycle.
module sram_resp_fifo #(
    parameter int DW = sram_ctrl_pkg::DW
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);
    import sram_ctrl_pkg::*;

    logic [DW-1:0] slot_q [2];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    count_q;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = slot_q[rd_q];

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_q] <= push_data;
                wr_q         <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/sram_ctrl_64x64.sv
// Single-port SRAM macro controller: zero-fills the macro after reset, then serves
// reads and writes with an ordered two-deep read response queue.
//
// state | meaning
// INIT  | writing zero to every word, one address per cycle; requests refused
// RUN   | requests forwarded to the macro; read data queued for the client
module sram_ctrl_64x64 #(
    parameter int DW    = sram_ctrl_pkg::DW,
    parameter int DEPTH = sram_ctrl_pkg::DEPTH,
    parameter int AW    = sram_ctrl_pkg::AW
) (
    input  logic             CLK,
    input  logic             RSTB,
    sram_ctrl_64x64_if.slave bus,
    output logic             SRAM_CEB,
    output logic             SRAM_WEB,
    output logic [AW-1:0]    SRAM_A,
    output logic [DW-1:0]    SRAM_D,
    input  logic [DW-1:0]    SRAM_Q
);
    import sram_ctrl_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;
    logic [AW-1:0] a_q;
    logic [DW-1:0] d_q;
    logic          rd_inflight_q;

    logic          run;
    logic          ready;
    logic          accept;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic [1:0]    buffered;
    logic [2:0]    pending;

    // A pop in this cycle frees a slot, which keeps reads streaming at one per cycle.
    assign buffered = fifo_full ? 2'd2 : {1'b0, ~fifo_empty};
    assign pending  = {1'b0, buffered} + {2'b0, rd_inflight_q} - {2'b0, fifo_pop};
    assign fifo_pop = !fifo_empty && bus.resp_ready;

    assign run    = (state_q == RUN);
    assign ready  = run && (bus.req_write || (pending < 3'd2));
    assign accept = bus.req_valid && ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        mem_a   = a_q;
        mem_d   = d_q;
        case (state_q)
            INIT: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
                mem_a  = ptr_q;
                mem_d  = '0;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    mem_en = 1'b1;
                    mem_we = bus.req_write;
                    mem_a  = bus.req_addr;
                    mem_d  = bus.req_wdata;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q       <= INIT;
            ptr_q         <= '0;
            a_q           <= '0;
            d_q           <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rd_inflight_q <= accept && !bus.req_write;
            if (mem_en) begin
                a_q <= mem_a;
                d_q <= mem_d;
            end
        end
    end

    // INIT drives the macro combinationally, so reset must mask the strobes directly.
    assign SRAM_CEB = ~(mem_en & RSTB);
    assign SRAM_WEB = ~(mem_we & RSTB);
    assign SRAM_A   = mem_a;
    assign SRAM_D   = mem_d;

    sram_resp_fifo #(
        .DW (DW)
    ) u_resp_fifo (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .push      (rd_inflight_q),
        .push_data (SRAM_Q),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.req_ready  = ready;
    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_rdata = fifo_rdata;
    assign bus.init_done  = run;

endmodule

// File: doc/sram_ctrl_64x64.md
SRAM_CTRL_64X64 -- requirements
Module: sram_ctrl_64x64

Interface
REQ-001 SHALL have parameter DW, default 64, meaning data width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, meaning number of macro words.
REQ-003 SHALL have parameter AW, default 6, meaning address width, equal to log2(DEPTH).
REQ-004 SHALL have one clock and asynchronous active-low reset: CLK  input  1  clock; RSTB  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-007 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  AW  word address.
REQ-009 SHALL have port req_wdata  input  DW  write data.
REQ-010 SHALL have port resp_valid  output  1  read data available.
REQ-011 SHALL have port resp_ready  input  1  consumer takes the response.
REQ-012 SHALL have port resp_rdata  output  DW  read data.
REQ-013 SHALL have port init_done  output  1  zero-fill complete.
REQ-014 SHALL have macro-side ports: SRAM_CEB  output  1  chip enable (active low); SRAM_WEB  output  1  write enable (active low); SRAM_A  output  AW  address; SRAM_D  output  DW  write data; SRAM_Q  input  DW  read data.

Function
REQ-015 SHALL implement a two-state FSM, INIT and RUN; reset enters INIT with init pointer 0.
REQ-016 In INIT, SHALL drive SRAM_CEB=0, SRAM_WEB=0, SRAM_A=pointer, SRAM_D=0 each cycle; the pointer SHALL increment per cycle.
REQ-017 In INIT, after the write to address DEPTH-1, SHALL go to RUN; init_done SHALL be 1 only in RUN.
REQ-018 In INIT, req_ready SHALL be 0.
REQ-019 In RUN, writes SHALL be ready whenever in RUN; reads SHALL be ready only when (buffered responses + reads in flight) < 2.
REQ-020 On an accepted request in cycle t, SHALL drive the macro ports combinationally in cycle t: SRAM_CEB=0, SRAM_WEB=~req_write, SRAM_A=req_addr, SRAM_D=req_wdata.
REQ-021 Otherwise, SHALL drive SRAM_CEB=1, SRAM_WEB=1; SRAM_A and SRAM_D SHALL hold their last values.
REQ-022 SHALL sample SRAM_Q only in cycle t+1 after a read issued in cycle t; SRAM_Q SHALL be ignored in all other cycles.
REQ-023 For a read accepted in cycle t, SHALL push the sampled SRAM_Q into a 2-entry response FIFO; resp_valid SHALL be visible from cycle t+2 at the earliest.
REQ-024 Writes SHALL produce no response.
REQ-025 Responses SHALL be returned in read-issue order.
REQ-026 A response SHALL pop on resp_valid && resp_ready.
REQ-027 resp_valid and resp_rdata SHALL hold stable while resp_ready is 0.
REQ-028 If a push and a pop occur in the same cycle with the FIFO full, both SHALL be honoured; the occupancy accounting in REQ-019 SHALL make overflow impossible.
REQ-029 A write followed by a read of the same address in the next cycle SHALL return the new data, with no hazard logic needed.
REQ-030 SHALL support back-to-back reads at one per cycle while resp_ready=1.

Reset
REQ-031 On RSTB=0, SHALL clear all state asynchronously: FSM=INIT, pointer=0, FIFO empty, in-flight flag=0.
REQ-032 Reset values of outputs SHALL be: req_ready=0, resp_valid=0, resp_rdata=0, init_done=0, SRAM_CEB=1, SRAM_WEB=1, SRAM_A=0, SRAM_D=0.
REQ-033 Reset mid-INIT or mid-read SHALL discard in-flight data; zero-fill SHALL restart from address 0 after RSTB rises.

Structure
REQ-034 Constants DW, DEPTH and AW, and the FSM state enum {INIT, RUN}, SHALL live in shared package sram_ctrl_pkg.
REQ-035 The response queue SHALL be sub-module sram_resp_fifo: 2 entries, registered, with push/pop/full/empty.
REQ-036 The macro SHALL be instantiated outside this block.

Verification
REQ-037 Release reset with req_valid=1 -> req_ready=0 for 64 cycles; SRAM_A steps 0..63 with SRAM_WEB=0 and SRAM_D=0; init_done=1 in the next cycle; a subsequent read of address 17 returns 0.
REQ-038 Write 0xDEADBEEF_00000005 to address 5, read address 5 in the next cycle -> resp_valid 2 cycles after the read is accepted, with resp_rdata=0xDEADBEEF_00000005.
REQ-039 Hold resp_ready=0 and issue reads of addresses 1,2,3 -> only two are accepted, the third waits with req_ready=0; raising resp_ready returns data in order 1,2,3.
REQ-040 Stream reads of addresses 0..63 with resp_ready=1 -> one response per cycle, in order, with no dropped responses.
REQ-041 Assert RSTB=0 at init pointer 30 -> all outputs take their reset values immediately; after release, zero-fill restarts at address 0.
REQ-042 Assert RSTB=0 with 2 responses buffered -> resp_valid=0 immediately; no stale data appears after re-init.
